serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
- Parametrised, multi-cycle successor to the team's combinational adder cells.
- Adds or subtracts two WIDTH-bit operands, LSB-first, BITS_PER_CYCLE bits per clock, using one registered carry between slices.
- Uses valid/ready handshakes on input and output, so it drops into any streaming datapath where area matters more than throughput.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH exactly. Violating this is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. With sub=1, cout=1 means no borrow.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- Reset, and any time rst_n is low:
  - State goes to IDLE.
  - Slice counter, carry register and operand/result shift registers clear to 0.
  - sum=0, cout=0, overflow=0, out_valid=0.
  - in_ready=1, because in_ready is decoded from IDLE.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready:
    - capture a, and b (or ~b when sub=1), into shift registers;
    - carry register = sub ? 1 : cin;
    - counter = 0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - add the low BITS_PER_CYCLE bits of the A and B registers plus carry;
    - shift the slice result in at the top of the result register, so the final result is LSB-aligned;
    - shift both operand registers right by BITS_PER_CYCLE;
    - update the carry register.
    - On the last slice (counter = WIDTH/BITS_PER_CYCLE-1): latch cout and overflow, go to DONE. Otherwise increment the counter.
  - DONE: out_valid=1. sum, cout and overflow are held stable. On out_ready go to IDLE.
- Latency:
  - out_valid rises exactly WIDTH/BITS_PER_CYCLE cycles after the accepting edge.
  - Minimum initiation interval is WIDTH/BITS_PER_CYCLE+2 cycles.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - overflow requires the carry into bit WIDTH-1. Compute it inside the final slice; do not derive it from the registered inter-slice carry.
- Boundary conditions:
  - in_valid while not IDLE is ignored; operand inputs are don't-care.
  - in_valid and out_ready both high in DONE: only the output handshake completes. New operands are accepted no earlier than the next cycle in IDLE.
  - sum/cout/overflow keep their last values in IDLE and RUN until overwritten at the end of the next RUN. Consumers qualify them with out_valid only.
  - rst_n asserted mid-RUN or in DONE: the transaction is dropped and the block is in IDLE immediately, without waiting for a clock edge. No stale out_valid after release.
  - Input operands need only be stable on the accepting edge.

Test Plan:
1. WIDTH=8, BPC=1: a=8'h0F, b=8'h01, cin=0, sub=0 -> sum=8'h10, cout=0, overflow=0. out_valid rises exactly 8 cycles after the accepting edge; in_ready=0 in between.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, overflow=1. Then a=8'h00, b=8'h00, cin=1 -> sum=8'h01.
3. sub=1 with cin=1 (must be ignored):
   - a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, overflow=0.
   - a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, overflow=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> sum/cout/overflow/out_valid unchanged, in_ready=0, new operands not captured. out_ready=1 -> IDLE next cycle, then the next operands accept normally.
5. Deassert rst_n 3 cycles into RUN -> in_ready=1 and out_valid=0 asynchronously, sum=0. After release, a=8'h12, b=8'h34 -> sum=8'h46 with standard latency.
6. WIDTH=16, BPC=4: a=16'hFFFF, b=16'h0001 -> sum=16'h0000, cout=1, out_valid 4 cycles after accept. Then 1000 random a/b/cin/sub with random out_ready stalls, each checked against a reference model.

Source files
------------

// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if: operand/result handshake bundle for serial_adder_n.
//   master: in_valid, a, b, cin, sub, out_ready  -> adder
//   slave : in_ready, out_valid, sum, cout, overflow -> source/sink
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle LSB-first add/subtract, BITS_PER_CYCLE bits per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_adder_n_if (operands in, result out, valid/ready each way)
module serial_adder_n #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_n_if.slave bus
);
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || BPC < 1 || WIDTH % BPC != 0) begin : g_bad_params
    $error("serial_adder_n: BITS_PER_CYCLE must divide WIDTH and WIDTH must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic             r_cout, r_ovf;
  logic [BPC:0]     w_slice;
  logic             w_msb_cin;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nx;
  assign w_slice   = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + {{BPC{1'b0}}, r_carry};
  // carry into the slice's top bit recovered from its sum bit; in the last slice this is the carry into the MSB
  assign w_msb_cin = r_a[BPC-1] ^ r_b[BPC-1] ^ w_slice[BPC-1];
  // slice bits enter at the top so that after N slices the result is LSB-aligned
  assign w_acc_nx  = WIDTH'({w_slice[BPC-1:0], r_acc} >> BPC);
  assign w_last    = r_cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  always_comb begin
    w_state_nx    = r_state;
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    case (r_state)
      IDLE:    w_state_nx = bus.in_valid ? RUN : IDLE;
      RUN:     w_state_nx = w_last ? DONE : RUN;
      DONE:    w_state_nx = bus.out_ready ? IDLE : DONE;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && bus.in_valid) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub | bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> BPC;
      r_b     <= r_b >> BPC;
      r_carry <= w_slice[BPC];
      r_acc   <= w_acc_nx;
      r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_nx;
        r_cout <= w_slice[BPC];
        r_ovf  <= w_msb_cin ^ w_slice[BPC];
      end
    end
  end
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: scoreboard bench for serial_adder_n at 8/1 and 16/4 configurations.
module tb_serial_adder_n;
  typedef struct packed {logic [15:0] s; logic co; logic ov;} exp_t;
  typedef struct packed {logic [7:0] a, b; logic c, s; logic [7:0] sum; logic co, ov;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q8[$];
  exp_t q16[$];
  serial_adder_n_if #(.WIDTH(8))  bus8();
  serial_adder_n_if #(.WIDTH(16)) bus16();
  serial_adder_n #(.WIDTH(8),  .BITS_PER_CYCLE(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_n #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic c, logic s);
    logic [16:0] t;
    logic [15:0] m, bb;
    exp_t e;
    m    = 16'((17'd1 << w) - 17'd1);
    bb   = s ? (~b & m) : (b & m);
    t    = 17'(a & m) + 17'(bb) + 17'(s | c);
    e.s  = t[15:0] & m;
    e.co = t[w];
    e.ov = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.sub = s; bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
  endtask
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    bus16.a = a; bus16.b = b; bus16.cin = c; bus16.sub = s; bus16.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a = 16'($urandom); bus16.b = 16'($urandom);
  endtask
  task automatic wait8(output int lat, output int rdy);
    lat = 0; rdy = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      rdy += int'(bus8.in_ready);
    end
  endtask
  task automatic wait16(output int lat);
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic ack8();
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask
  task automatic ack16();
    bus16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset8 got rdy=%b vld=%b sum=%h cout=%b ovf=%b want rdy=1 vld=0 sum=00 cout=0 ovf=0",
               bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow);
    end
    checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.sum, bus16.cout, bus16.overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset16 got rdy=%b vld=%b sum=%h cout=%b ovf=%b want rdy=1 vld=0 sum=0000 cout=0 ovf=0",
               bus16.in_ready, bus16.out_valid, bus16.sum, bus16.cout, bus16.overflow);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_add_sub();
    vec_t v[7];
    exp_t e;
    int lat, rdy;
    v = '{'{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0},
          '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
          '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
          '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0},
          '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0},
          '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1},
          '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      q8.push_back('{s: 16'(v[i].sum), co: v[i].co, ov: v[i].ov});
      send8(v[i].a, v[i].b, v[i].c, v[i].s);
      wait8(lat, rdy);
      e = q8.pop_front();
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL add_sub[%0d] latency got=%0d want=8", i, lat);
      end
      checks++;
      if (rdy != 0) begin
        errors++;
        $display("FAIL add_sub[%0d] in_ready high for %0d cycles while busy, want 0", i, rdy);
      end
      checks++;
      if ({bus8.sum, bus8.cout, bus8.overflow} !== {e.s[7:0], e.co, e.ov}) begin
        errors++;
        $display("FAIL add_sub[%0d] a=%h b=%h got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, v[i].a, v[i].b, bus8.sum, bus8.cout, bus8.overflow, e.s[7:0], e.co, e.ov);
      end
      ack8();
    end
  endtask
  task automatic test_backpressure();
    exp_t e;
    int lat, rdy;
    q8.push_back('{s: 16'h0033, co: 1'b0, ov: 1'b0});
    send8(8'h11, 8'h22, 1'b0, 1'b0);
    wait8(lat, rdy);
    e = q8.pop_front();
    checks++;
    if (lat != 8 || {bus8.sum, bus8.cout, bus8.overflow} !== {e.s[7:0], e.co, e.ov}) begin
      errors++;
      $display("FAIL bp_first got lat=%0d sum=%h cout=%b ovf=%b want lat=8 sum=%h cout=%b ovf=%b",
               lat, bus8.sum, bus8.cout, bus8.overflow, e.s[7:0], e.co, e.ov);
    end
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus8.out_valid, bus8.in_ready, bus8.sum, bus8.cout, bus8.overflow} !== {1'b1, 1'b0, e.s[7:0], e.co, e.ov}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                 i, bus8.out_valid, bus8.in_ready, bus8.sum, bus8.cout, bus8.overflow, e.s[7:0], e.co, e.ov);
      end
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    checks++;
    if ({bus8.out_valid, bus8.in_ready, bus8.sum} !== {1'b0, 1'b1, e.s[7:0]}) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=%h",
               bus8.out_valid, bus8.in_ready, bus8.sum, e.s[7:0]);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_capture in_ready got=%b want=1", bus8.in_ready);
    end
    q8.push_back('{s: 16'h0003, co: 1'b0, ov: 1'b0});
    send8(8'h01, 8'h02, 1'b0, 1'b0);
    wait8(lat, rdy);
    e = q8.pop_front();
    checks++;
    if (lat != 8 || {bus8.sum, bus8.cout, bus8.overflow} !== {e.s[7:0], e.co, e.ov}) begin
      errors++;
      $display("FAIL bp_next got lat=%0d sum=%h cout=%b ovf=%b want lat=8 sum=%h cout=%b ovf=%b",
               lat, bus8.sum, bus8.cout, bus8.overflow, e.s[7:0], e.co, e.ov);
    end
    ack8();
  endtask
  task automatic test_reset_mid_run();
    exp_t e;
    int lat, rdy;
    send8(8'h99, 8'h11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got rdy=%b vld=%b sum=%h cout=%b ovf=%b want rdy=1 vld=0 sum=00 cout=0 ovf=0",
               bus8.in_ready, bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset got rdy=%b vld=%b want rdy=1 vld=0", bus8.in_ready, bus8.out_valid);
    end
    q8.push_back('{s: 16'h0046, co: 1'b0, ov: 1'b0});
    send8(8'h12, 8'h34, 1'b0, 1'b0);
    wait8(lat, rdy);
    e = q8.pop_front();
    checks++;
    if (lat != 8 || {bus8.sum, bus8.cout, bus8.overflow} !== {e.s[7:0], e.co, e.ov}) begin
      errors++;
      $display("FAIL post_reset_add got lat=%0d sum=%h cout=%b ovf=%b want lat=8 sum=%h cout=%b ovf=%b",
               lat, bus8.sum, bus8.cout, bus8.overflow, e.s[7:0], e.co, e.ov);
    end
    ack8();
  endtask
  task automatic test_wide16();
    exp_t e;
    int lat;
    q16.push_back('{s: 16'h0000, co: 1'b1, ov: 1'b0});
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait16(lat);
    e = q16.pop_front();
    checks++;
    if (lat != 4 || {bus16.sum, bus16.cout, bus16.overflow} !== {e.s, e.co, e.ov}) begin
      errors++;
      $display("FAIL wide16 got lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=%h cout=%b ovf=%b",
               lat, bus16.sum, bus16.cout, bus16.overflow, e.s, e.co, e.ov);
    end
    ack16();
  endtask
  task automatic test_random16();
    exp_t e;
    int lat;
    logic [15:0] a, b;
    logic c, s;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
      if (i % 50 == 0) a = 16'h8000;
      q16.push_back(model(16, a, b, c, s));
      send16(a, b, c, s);
      wait16(lat);
      e = q16.pop_front();
      checks++;
      if (lat != 4 || {bus16.sum, bus16.cout, bus16.overflow} !== {e.s, e.co, e.ov}) begin
        errors++;
        $display("FAIL rand16[%0d] a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=%h cout=%b ovf=%b",
                 i, a, b, c, s, lat, bus16.sum, bus16.cout, bus16.overflow, e.s, e.co, e.ov);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus16.out_valid, bus16.sum, bus16.cout, bus16.overflow} !== {1'b1, e.s, e.co, e.ov}) begin
          errors++;
          $display("FAIL rand16_stall[%0d] got vld=%b sum=%h want vld=1 sum=%h", i, bus16.out_valid, bus16.sum, e.s);
        end
      end
      ack16();
    end
  endtask
  initial begin
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    test_reset();
    test_add_sub();
    test_backpressure();
    test_reset_mid_run();
    test_wide16();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
